// File: rtl/booth_operand_issuer_pkg.sv
// Shared types for the Booth multiplier operand issuer: the issue FSM
// state encoding and the operand pair carried through the queue.
package booth_pkg;

    localparam int BOOTH_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic signed [BOOTH_WIDTH-1:0] mcand;
        logic signed [BOOTH_WIDTH-1:0] mplier;
    } operand_pair_t;

    function automatic operand_pair_t make_pair(
        input logic signed [BOOTH_WIDTH-1:0] mcand,
        input logic signed [BOOTH_WIDTH-1:0] mplier
    );
        operand_pair_t p;
        p.mcand  = mcand;
        p.mplier = mplier;
        return p;
    endfunction

endpackage

// File: rtl/booth_operand_issuer_fifo.sv
// Synchronous FIFO of operand pairs. Registered storage with no
// fall-through: an entry written on one edge is visible at the head only
// after that edge. A push while full is dropped even if a pop happens in
// the same cycle.
module issue_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  operand_pair_t din,
    input  logic          pop,
    output operand_pair_t dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    operand_pair_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless while not counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/booth_operand_issuer.sv
// Operand issuer for the 32-bit Booth multiplier. Queues signed operand
// pairs and hands them to the multiplier one at a time: load operands and
// pulse start, skip one cycle while the multiplier's done flag falls, then
// wait for done before issuing the next pair.
// Optional feature macro: BOOTH_ISSUE_TIMEOUT_EN adds a WAIT watchdog that
// aborts after TIMEOUT cycles and raises a sticky err flag.
// WIDTH must equal booth_pkg::BOOTH_WIDTH, which sizes the queued pair.
module booth_operand_issuer
    import booth_pkg::*;
#(
    parameter int WIDTH   = BOOTH_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mcand,
    input  logic [WIDTH-1:0] in_mplier,
    input  logic             mul_done,
    output logic [WIDTH-1:0] mul_mcand,
    output logic [WIDTH-1:0] mul_mplier,
    output logic             mul_start,
    output logic             busy,
    output logic [15:0]      issued_cnt,
    output logic             err
);

    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    issue_state_t  state;
    issue_state_t  state_next;
    operand_pair_t push_pair;
    operand_pair_t head_pair;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          timeout;

    logic signed [WIDTH-1:0] mcand_q;
    logic signed [WIDTH-1:0] mplier_q;

    assign push_pair = make_pair(in_mcand, in_mplier);
    assign in_ready  = !fifo_full;

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .din   (push_pair),
        .pop   (pop),
        .dout  (head_pair),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state: one transition per edge; GUARD ignores done while it falls.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty && mul_done) state_next = START;
            START:   state_next = GUARD;
            GUARD:   state_next = WAIT;
            WAIT:    if (mul_done || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: pop the head when leaving IDLE, start strobe during START.
    always_comb begin
        pop       = (state == IDLE) && !fifo_empty && mul_done;
        mul_start = (state == START);
        busy      = (state != IDLE) || (fifo_count != '0);
    end

    // Operand registers: loaded only on the IDLE->START edge, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (pop) begin
            mcand_q  <= head_pair.mcand;
            mplier_q <= head_pair.mplier;
        end
    end

    assign mul_mcand  = mcand_q;
    assign mul_mplier = mplier_q;

    // Count pairs whose multiply completed (WAIT left via done, not via abort).
    always_ff @(posedge clk) begin
        if (reset)                        issued_cnt <= '0;
        else if (state == WAIT && mul_done) issued_cnt <= issued_cnt + 16'd1;
    end

`ifdef BOOTH_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          err_q;

    // Watchdog fires at the end of the TIMEOUT-th WAIT cycle without done.
    assign timeout = (state == WAIT) && !mul_done && (wait_cnt == TW'(TIMEOUT - 1));
    assign err     = err_q;

    // WAIT-cycle counter, cleared on entry to WAIT.
    always_ff @(posedge clk) begin
        if (reset)               wait_cnt <= '0;
        else if (state == GUARD) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)        err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
